// File: rtl/y86_data_mem.sv
// -----------------------------------------------------------------------------
// y86_data_mem
// Byte-addressed Y86-64 data memory for the CPU memory stage. Every access
// moves 8 bytes, little-endian, starting at any byte address. Each access
// takes a programmable number of wait states and finishes with a one-cycle
// mem_done pulse. mem_err on that pulse marks a rejected access.
//
// Parameters
//    MEM_BYTES    storage size in bytes (multiple of 8, at least 16)
//    WAIT_CYCLES  extra wait states per access (0..255)
//
// Ports
//    clk        in   1   clock, rising edge
//    rst        in   1   synchronous active-high reset
//    mem_read   in   1   read request (level), sampled only in IDLE
//    mem_write  in   1   write request (level), sampled only in IDLE
//    mem_addr   in   64  byte address of the lowest byte
//    mem_wdata  in   64  write data, byte 0 = bits [7:0]
//    mem_rdata  out  64  read data, held until the next read completion
//    mem_busy   out  1   high in every state except IDLE
//    mem_done   out  1   one-cycle completion pulse
//    mem_err    out  1   qualifies mem_done: access rejected
//
// Optional feature
//    DMEM_CLEAR_EN  when defined, each reset is followed by a CLEAR sweep
//                   that zeroes the storage 8 bytes per cycle. When it is
//                   undefined, reset leaves the storage contents unchanged.
// -----------------------------------------------------------------------------
module y86_data_mem #(
   parameter int MEM_BYTES   = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [63:0] mem_addr,
   input  logic [63:0] mem_wdata,
   output logic [63:0] mem_rdata,
   output logic        mem_busy,
   output logic        mem_done,
   output logic        mem_err
);

   localparam int          ADDR_W    = $clog2(MEM_BYTES);
   localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

`ifdef DMEM_CLEAR_EN
   typedef enum logic [1:0] {IDLE, WAIT, RESP, CLEAR} state_t;
`else
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
`endif

   state_t              state;
   state_t              next_state;
   logic [7:0]          cnt;
   logic                op_write;
   logic                both_q;
   logic [63:0]         addr_q;
   logic [63:0]         wdata_q;
   logic                access_err;
   logic                do_access;
   logic                clear_go;
   logic [ADDR_W-1:0]   base;
   logic [63:0]         read_word;
   logic [7:0]          store [MEM_BYTES];

`ifdef DMEM_CLEAR_EN
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(MEM_BYTES - 8);
   logic                clear_pend;
   logic [ADDR_W-1:0]   clear_ptr;
   assign clear_go = clear_pend;
`else
   assign clear_go = 1'b0;
`endif

   // The range check uses the full 64-bit latched address, so addresses near
   // 2^64 are rejected rather than wrapping into the array. A request with
   // both read and write high is always rejected.
   assign access_err = (addr_q > LAST_ADDR) | both_q;
   assign do_access  = (state == WAIT) && (cnt == 8'd0);
   assign base       = addr_q[ADDR_W-1:0];

   // Status outputs are decoded straight from the state, so they drop in the
   // cycle right after a reset edge.
   always_comb begin
      mem_busy = (state != IDLE);
      mem_done = (state == RESP);
      mem_err  = (state == RESP) && access_err;
   end

   // Gather the 8 bytes starting at the latched address, lowest address in
   // the least significant byte.
   always_comb begin
      read_word = '0;
      for (int i = 0; i < 8; i++)
         read_word[8*i +: 8] = store[base + ADDR_W'(i)];
   end

   // State register. Reset always returns to IDLE, which abandons any
   // access in flight.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic. Requests are only looked at in IDLE. A pending clear
   // takes priority over a request on the first edge after reset.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
`ifdef DMEM_CLEAR_EN
            if (clear_pend)
               next_state = CLEAR;
            else
`endif
            if (mem_read | mem_write)
               next_state = WAIT;
         end
         WAIT: begin
            if (cnt == 8'd0)
               next_state = RESP;
         end
         RESP: next_state = IDLE;
`ifdef DMEM_CLEAR_EN
         CLEAR: begin
            if (clear_ptr == LAST_PTR)
               next_state = IDLE;
         end
`endif
         default: next_state = IDLE;
      endcase
   end

   // Request capture, wait-state counting and read-data return. The read
   // result is loaded at the access edge and then held. A rejected read
   // returns zero. A completed write leaves mem_rdata alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= 8'd0;
         op_write  <= 1'b0;
         both_q    <= 1'b0;
         addr_q    <= 64'd0;
         wdata_q   <= 64'd0;
         mem_rdata <= 64'd0;
`ifdef DMEM_CLEAR_EN
         clear_pend <= 1'b1;
         clear_ptr  <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (!clear_go && (mem_read | mem_write)) begin
                  op_write <= mem_write & ~mem_read;
                  both_q   <= mem_write & mem_read;
                  addr_q   <= mem_addr;
                  wdata_q  <= mem_wdata;
                  cnt      <= 8'(WAIT_CYCLES);
               end
`ifdef DMEM_CLEAR_EN
               if (clear_pend) begin
                  clear_pend <= 1'b0;
                  clear_ptr  <= '0;
               end
`endif
            end
            WAIT: begin
               if (cnt != 8'd0)
                  cnt <= cnt - 8'd1;
               else if (!op_write)
                  mem_rdata <= access_err ? 64'd0 : read_word;
            end
`ifdef DMEM_CLEAR_EN
            CLEAR: clear_ptr <= clear_ptr + ADDR_W'(8);
`endif
            default: ;
         endcase
      end
   end

   // Byte storage has no reset. All 8 bytes of a write land on the same
   // edge, and a reset on that edge blocks the write completely. A rejected
   // write touches nothing.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (do_access && op_write && !access_err) begin
            for (int i = 0; i < 8; i++)
               store[base + ADDR_W'(i)] <= wdata_q[8*i +: 8];
         end
`ifdef DMEM_CLEAR_EN
         if (state == CLEAR) begin
            for (int i = 0; i < 8; i++)
               store[clear_ptr + ADDR_W'(i)] <= 8'h00;
         end
`endif
      end
   end

endmodule

// File: tb/tb_y86_data_mem.sv
// -----------------------------------------------------------------------------
// tb_y86_data_mem
// Directed bench for y86_data_mem with MEM_BYTES=1024 and WAIT_CYCLES=1.
// Inputs are driven and outputs are sampled on the falling edge. The DUT
// acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_y86_data_mem;

   localparam int MEM_BYTES   = 1024;
   localparam int WAIT_CYCLES = 1;

   logic        clk;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;
   logic        mem_busy;
   logic        mem_done;
   logic        mem_err;

   int checks;
   int errors;

   y86_data_mem #(
      .MEM_BYTES  (MEM_BYTES),
      .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .mem_read (mem_read),
      .mem_write(mem_write),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata),
      .mem_busy (mem_busy),
      .mem_done (mem_done),
      .mem_err  (mem_err)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point. Every check goes through this task.
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete access. The request is raised before an edge, so that edge
   // accepts it. The request is dropped after the accept edge unless hold is
   // set. The task then waits, with a bound, for mem_done. lat counts rising
   // edges after the accept edge until done is visible.
   task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic hold,
                                output logic [63:0] rdata, output logic err, output int lat);
      logic got;
      got   = 1'b0;
      lat   = -1;
      rdata = 64'd0;
      err   = 1'b0;
      @(negedge clk);
      mem_read  = rd;
      mem_write = wr;
      mem_addr  = addr;
      mem_wdata = wdata;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 0 && !hold) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         if (mem_done) begin
            got   = 1'b1;
            lat   = k;
            rdata = mem_rdata;
            err   = mem_err;
            break;
         end
      end
      if (!got)
         checkOutput("done_timeout", 64'd0, 64'd1);
   endtask

   // Counts falling edges with busy high after reset is released. The count
   // stops at the first idle cycle and is bounded.
   task automatic waitClear(output int n);
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (mem_busy)
            n++;
         else
            break;
      end
   endtask

   logic [63:0] rd_data;
   logic        rd_err;
   int          lat;
   int          n_busy;
   int          extra_done;
   int          clear_expect;

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = 64'd0;
      mem_wdata = 64'd0;
`ifdef DMEM_CLEAR_EN
      clear_expect = MEM_BYTES / 8;
`else
      clear_expect = 0;
`endif

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("rst_busy",  64'(mem_busy),  64'd0);
      checkOutput("rst_done",  64'(mem_done),  64'd0);
      checkOutput("rst_err",   64'(mem_err),   64'd0);
      checkOutput("rst_rdata", mem_rdata,      64'd0);
      rst = 1'b0;
      waitClear(n_busy);
      checkOutput("clear_busy_cycles", 64'(n_busy), 64'(clear_expect));

      // Aligned write, then read back. Done is seen WAIT_CYCLES+1 edges
      // after the accept edge, which is the third cycle counting the
      // accept cycle.
      applyStimulus(1'b0, 1'b1, 64'h10, 64'h1122334455667788, 1'b0, rd_data, rd_err, lat);
      checkOutput("wr10_lat", 64'(lat),   64'(WAIT_CYCLES + 1));
      checkOutput("wr10_err", 64'(rd_err), 64'd0);
      applyStimulus(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("rd10_data", rd_data,     64'h1122334455667788);
      checkOutput("rd10_err",  64'(rd_err), 64'd0);
      checkOutput("rd10_lat",  64'(lat),    64'(WAIT_CYCLES + 1));

      // Unaligned read spanning the two words
      applyStimulus(1'b0, 1'b1, 64'h18, 64'd0, 1'b0, rd_data, rd_err, lat);
      applyStimulus(1'b1, 1'b0, 64'h13, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("rd13_data", rd_data, 64'h0000001122334455);

      // Upper bound
      applyStimulus(1'b0, 1'b1, 64'h3F8, 64'hCAFEF00DDEADBEEF, 1'b0, rd_data, rd_err, lat);
      checkOutput("wr3f8_err", 64'(rd_err), 64'd0);
      applyStimulus(1'b1, 1'b0, 64'h3F8, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("rd3f8_err",  64'(rd_err), 64'd0);
      checkOutput("rd3f8_data", rd_data,     64'hCAFEF00DDEADBEEF);
      applyStimulus(1'b1, 1'b0, 64'h3F9, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("rd3f9_err",  64'(rd_err), 64'd1);
      checkOutput("rd3f9_data", rd_data,     64'd0);
      applyStimulus(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, 1'b0, rd_data, rd_err, lat);
      checkOutput("wrwrap_err", 64'(rd_err), 64'd1);
      applyStimulus(1'b1, 1'b0, 64'h3F8, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("rd3f8_after_wrap", rd_data, 64'hCAFEF00DDEADBEEF);

      // Read and write together: rejected, storage unchanged
      applyStimulus(1'b1, 1'b1, 64'h10, 64'hDEADDEADDEADDEAD, 1'b0, rd_data, rd_err, lat);
      checkOutput("both_err", 64'(rd_err), 64'd1);
      applyStimulus(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("both_keep", rd_data, 64'h1122334455667788);

      // Request held high through RESP: only one completion
      applyStimulus(1'b1, 1'b0, 64'h10, 64'd0, 1'b1, rd_data, rd_err, lat);
      checkOutput("hold_data", rd_data, 64'h1122334455667788);
      @(negedge clk);
      mem_read   = 1'b0;
      extra_done = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (mem_done)
            extra_done++;
      end
      checkOutput("hold_single_done", 64'(extra_done), 64'd0);

      // Reset during WAIT abandons the write
      applyStimulus(1'b0, 1'b1, 64'h20, 64'h0123456789ABCDEF, 1'b0, rd_data, rd_err, lat);
      @(negedge clk);
      mem_write = 1'b1;
      mem_addr  = 64'h20;
      mem_wdata = 64'hAAAAAAAAAAAAAAAA;
      @(negedge clk);
      mem_write = 1'b0;
      checkOutput("midrst_busy_wait", 64'(mem_busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("midrst_busy", 64'(mem_busy), 64'd0);
      checkOutput("midrst_done", 64'(mem_done), 64'd0);
      rst = 1'b0;
      waitClear(n_busy);
      checkOutput("midrst_clear_cycles", 64'(n_busy), 64'(clear_expect));
      applyStimulus(1'b1, 1'b0, 64'h20, 64'd0, 1'b0, rd_data, rd_err, lat);
`ifdef DMEM_CLEAR_EN
      checkOutput("midrst_old", rd_data, 64'd0);
      applyStimulus(1'b1, 1'b0, 64'h10, 64'd0, 1'b0, rd_data, rd_err, lat);
      checkOutput("clear_rd10", rd_data, 64'd0);
`else
      checkOutput("midrst_old", rd_data, 64'h0123456789ABCDEF);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
